// File: rtl/c64_bus_arbiter_if.sv
// Bus bundle between the C64 bus arbiter and its requesters (6502 core, VIC-II fetch
// engine) plus the shared RAM. The arbiter takes the slave view.
interface c64_bus_arbiter_if #(
  parameter int VIC_AW = 14
);
  // CPU side
  logic [15:0]       cpu_ab;
  logic              cpu_we;
  logic [7:0]        cpu_do;
  logic [7:0]        cpu_di;
  logic              cpu_ce;

  // VIC side
  logic [VIC_AW-1:0] vic_addr;
  logic [1:0]        vic_bank;
  logic              vic_steal_req;
  logic [7:0]        vic_data;
  logic              vic_data_valid;

  // Handshake and phase
  logic              ba;
  logic              aec;
  logic              phase;

  // RAM side
  logic [15:0]       mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  modport master (
    output cpu_ab, cpu_we, cpu_do, vic_addr, vic_bank, vic_steal_req, mem_rdata,
    input  cpu_di, cpu_ce, vic_data, vic_data_valid, ba, aec, phase,
           mem_addr, mem_we, mem_wdata
  );

  modport slave (
    input  cpu_ab, cpu_we, cpu_do, vic_addr, vic_bank, vic_steal_req, mem_rdata,
    output cpu_di, cpu_ce, vic_data, vic_data_valid, ba, aec, phase,
           mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/c64_bus_arbiter.sv
// Two-phase C64 memory bus arbiter: phase 0 is always a VIC fetch, phase 1 goes to the
// CPU unless the VIC has stolen it via the BA/AEC handshake.
module c64_bus_arbiter #(
  parameter int BA_LEAD = 3,   // CPU cycles of BA warning before a steal, 1..7
  parameter int VIC_AW  = 14   // bank bits fill the upper 16-VIC_AW address bits
) (
  input  logic             clk,
  input  logic             reset,
  c64_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BA_WAIT,
    ST_STEAL
  } state_e;

  localparam int         BANK_W    = 16 - VIC_AW;
  localparam logic [2:0] LEAD_LOAD = 3'(BA_LEAD - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        phase_q, phase_d;
  logic [7:0]  cpu_di_q, cpu_di_d;
  logic [7:0]  vic_data_q, vic_data_d;
  logic        vic_valid_q, vic_valid_d;

  logic        cpu_grant;
  logic        vic_slot;
  logic [15:0] vic_full_addr;

  assign vic_full_addr = {bus.vic_bank[BANK_W-1:0], bus.vic_addr};

  // NOTE: every always_comb output gets its default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    phase_d     = ~phase_q;
    cpu_grant   = 1'b0;
    vic_slot    = 1'b0;

    if (!phase_q) begin
      vic_slot = 1'b1;
    end else begin
      // Ownership of the slot and the state transition are both decided on phase 1.
      unique case (state_q)
        ST_IDLE: begin
          cpu_grant = 1'b1;
          if (bus.vic_steal_req) begin
            state_d = ST_BA_WAIT;
            cnt_d   = LEAD_LOAD;
          end
        end
        ST_BA_WAIT: begin
          // During the BA warning the CPU may still finish writes; reads stall.
          cpu_grant = bus.cpu_we;
          if (!bus.vic_steal_req) begin
            state_d = ST_IDLE;
          end else if (cnt_q == 3'd0) begin
            state_d = ST_STEAL;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        ST_STEAL: begin
          vic_slot = 1'b1;
          if (!bus.vic_steal_req) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    cpu_di_d    = (cpu_grant && !bus.cpu_we) ? bus.mem_rdata : cpu_di_q;
    vic_data_d  = vic_slot ? bus.mem_rdata : vic_data_q;
    vic_valid_d = vic_slot;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      phase_q     <= 1'b0;
      cpu_di_q    <= 8'h00;
      vic_data_q  <= 8'h00;
      vic_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      cpu_di_q    <= cpu_di_d;
      vic_data_q  <= vic_data_d;
      vic_valid_q <= vic_valid_d;
    end
  end

  // Reset gates the strobes so a half-finished write cannot land in the reset cycle.
  assign bus.mem_addr       = vic_slot ? vic_full_addr : bus.cpu_ab;
  assign bus.mem_we         = cpu_grant & bus.cpu_we & ~reset;
  assign bus.mem_wdata      = bus.cpu_do;
  assign bus.cpu_ce         = cpu_grant & ~reset;
  assign bus.cpu_di         = cpu_di_q;
  assign bus.vic_data       = vic_data_q;
  assign bus.vic_data_valid = vic_valid_q;
  assign bus.ba             = (state_q == ST_IDLE);
  assign bus.aec            = (state_q != ST_STEAL);
  assign bus.phase          = phase_q;

  a_no_vic_write: assert property (@(posedge clk) !(bus.mem_we && vic_slot));
  a_no_ce_phase0: assert property (@(posedge clk) !(bus.cpu_ce && !phase_q));

endmodule
